serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial ripple adder: one full-adder slice plus a carry flip-flop, time-multiplexed over WIDTH cycles.
//  Parallel operands are captured on a start pulse, shifted LSB-first through the slice, and returned as a
//  parallel sum with carry-out.
//  Sits upstream of result consumers and shares the combinational full-adder equations
//  (S = A^B^Cin, Cout = AB | ACin | BCin) with the rest of the arithmetic set.
//  Used where area matters more than latency.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits (>= 2); also the number of compute cycles
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled each edge, accepted only in IDLE or DONE
//  a       in   WIDTH  operand A, captured on accepted start
//  b       in   WIDTH  operand B, captured on accepted start
//  cin     in   1      carry-in, captured on accepted start
//  busy    out  1      high while state == RUN
//  done    out  1      one-cycle pulse: sum/cout valid
//  sum     out  WIDTH  result (A + B + Cin) mod 2^WIDTH; held until next accepted start
//  cout    out  1      carry out of bit WIDTH-1; held with sum
// BEHAVIOUR
//  Reset (rst_n low, asynchronous):
//  - state = IDLE; busy = 0; done = 0; sum = 0; cout = 0.
//  - Operand shift registers, carry FF and bit counter are cleared.
//  - Reset asserted mid-RUN aborts the operation; no done pulse.
//  States:
//  - IDLE -> RUN on start.
//  - RUN -> DONE after WIDTH bit-steps.
//  - DONE -> RUN on start, else DONE -> IDLE.
//  Accept (edge k, start=1 in IDLE/DONE):
//  - Capture a_sr <= a, b_sr <= b, carry <= cin.
//  - cnt <= 0; sum_sr <= 0; enter RUN.
//  - sum/cout outputs change here (sum goes to 0 when the accumulator clears).
//  RUN step (edges k+1 .. k+WIDTH):
//  - s = a_sr[0]^b_sr[0]^carry; carry <= majority(a_sr[0], b_sr[0], carry).
//  - a_sr, b_sr shift right by 1; sum_sr <= {s, sum_sr[WIDTH-1:1]}; cnt <= cnt + 1.
//  - Step with cnt == WIDTH-1 is the last one: next state DONE.
//  - cout = final carry; sum = sum_sr after WIDTH shifts (bit 0 ends at LSB).
//  Timing:
//  - done is high exactly one cycle, the cycle after edge k+WIDTH.
//  - Latency from start-sample edge to done-high edge is WIDTH edges.
//  - busy is high for WIDTH cycles.
//  Boundary conditions:
//  - start while RUN: ignored; operands are not re-captured.
//  - start during the done cycle: accepted (back-to-back); done still pulses; next op begins.
//  - start held high continuously: one operation per WIDTH+1 cycles.
//  - a/b/cin changes after accept do not affect the result.
//  - Overflow wraps mod 2^WIDTH; the lost bit appears only on cout.
//  - cnt is $clog2(WIDTH)+1 bits wide; no wrap inside RUN.
// TESTING (WIDTH=8)
//  - Reset: pulse rst_n low asynchronously -> busy=0, done=0, sum=00, cout=0 immediately (no clock edge needed).
//  - a=FF, b=01, cin=0, start 1 cycle -> busy 8 cycles, done 8 edges after accept, sum=00, cout=1.
//  - a=5A, b=A5, cin=1 -> sum=00, cout=1; a=12, b=34, cin=0 -> sum=46, cout=0.
//  - start re-pulsed mid-RUN with a=00,b=00 -> ignored; first result unchanged and done pulses once.
//  - start held high with a=01,b=01,cin=0 -> done every 9 cycles, sum=02 each time.
//  - rst_n low at step 4 of a run -> immediate IDLE, no done pulse; next start yields the correct sum.
//  - Random: 200 operands vs a+b+cin golden model, checked at every done.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flop, iterated LSB-first over WIDTH cycles.
// Latency: WIDTH cycles from accepted start to the one-cycle done pulse.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c;

    assign fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = cin;
                    sum_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                carry_d  = fa_c;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_sr_q;
    assign cout = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=8): directed vectors plus random operands, scoreboard-checked at done.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         cout;

    typedef struct {
        logic [W-1:0] es;
        logic         ec;
        int           edge_n;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   busy_cnt = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse; a done with nothing pending is a failure.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                check("stray_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e.es));
                check("cout", 32'(cout), 32'(e.ec));
                check("latency", 32'(cyc - e.edge_n), 32'(W));
                check("busy_cycles", 32'(busy_cnt), 32'(W));
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end
    end

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                         input logic [W-1:0] es, input logic ec);
        @(posedge clk); #1;
        a = ta; b = tb2; cin = tc; start = 1'b1;
        exp_q.push_back('{es, ec, cyc + 1});
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ta; b = ta ^ 8'h3C; cin = ~tc;
        wait_done();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        #12 rst_n = 1'b1;

        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        do_op(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1);
        do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
        do_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1);
        do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // Start re-pulsed mid-run must be ignored.
        @(posedge clk); #1;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        exp_q.push_back('{8'h46, 1'b0, cyc + 1});
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 a = 8'h00; b = 8'h00; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        repeat (12) @(posedge clk);

        // Start held high: back-to-back ops every W+1 cycles.
        @(posedge clk); #1;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        exp_q.push_back('{8'h02, 1'b0, cyc + 1});
        for (int k = 0; k < 3; k++) begin
            wait_done();
            if (k < 2) exp_q.push_back('{8'h02, 1'b0, cyc + 1});
            else start = 1'b0;
        end
        repeat (12) @(posedge clk);

        // Asynchronous reset at step 4 aborts the run without a done pulse.
        @(posedge clk); #1;
        a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        do_op(8'hC3, 8'h3D, 1'b1, 8'h01, 1'b1);

        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            logic [W:0]   gold;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom);
            gold = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_op(ra, rb, rc, gold[W-1:0], gold[W]);
        end

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
